// File: rtl/weight_pingpong_buffer_pkg.sv
// weight_pingpong_buffer_pkg
// Shared definitions for the ping-pong weight buffer and the DRAM-to-memory
// packer that feeds it. Keeping the packed word width here means both blocks
// stay in step when the word format changes.
//   WPB_DATA_BITWIDTH : default width of one packed word.
//   WPB_BANK_BITWIDTH : width of a bank index (two banks).
//   wpb_bank_t        : bank index type.
//   wpb_addr_bitwidth : derives the per-bank word address width from DEPTH.
package weight_pingpong_buffer_pkg;

  localparam int unsigned WPB_DATA_BITWIDTH = 163;
  localparam int unsigned WPB_BANK_BITWIDTH = 1;

  typedef logic [WPB_BANK_BITWIDTH-1:0] wpb_bank_t;

  // A one-word bank would still need a one-bit address, so never return 0.
  function automatic int unsigned wpb_addr_bitwidth(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/weight_pingpong_buffer_if.sv
// weight_pingpong_buffer_if
// Write side (from the packer) and read side (to the PE-array reader) of the
// ping-pong weight buffer, bundled into one interface.
//   master : packer / reader side; drives write data, strobes, read address
//            and release, observes status and read data.
//   slave  : the buffer itself.
// Signals:
//   wr_data_i, wr_en_i, wr_last_i      : packed word, write strobe, end of tile
//   wr_full_o, wr_overflow_o           : write bank still owned by reader, sticky drop
//   rd_ready_o, rd_bank_o, rd_count_o  : read bank status
//   rd_en_i, rd_addr_i, rd_data_o      : read strobe, word address, registered data
//   rd_release_i                       : reader done with the read bank
interface weight_pingpong_buffer_if
  import weight_pingpong_buffer_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = WPB_DATA_BITWIDTH,
  parameter int unsigned DEPTH         = 64
);

  localparam int unsigned ADDR_BITWIDTH = wpb_addr_bitwidth(DEPTH);

  logic [DATA_BITWIDTH-1:0] wr_data_i;
  logic                     wr_en_i;
  logic                     wr_last_i;
  logic                     wr_full_o;
  logic                     wr_overflow_o;
  logic                     rd_ready_o;
  wpb_bank_t                rd_bank_o;
  logic [ADDR_BITWIDTH:0]   rd_count_o;
  logic                     rd_en_i;
  logic [ADDR_BITWIDTH-1:0] rd_addr_i;
  logic [DATA_BITWIDTH-1:0] rd_data_o;
  logic                     rd_release_i;

  modport master (
    output wr_data_i, wr_en_i, wr_last_i, rd_en_i, rd_addr_i, rd_release_i,
    input  wr_full_o, wr_overflow_o, rd_ready_o, rd_bank_o, rd_count_o, rd_data_o
  );

  modport slave (
    input  wr_data_i, wr_en_i, wr_last_i, rd_en_i, rd_addr_i, rd_release_i,
    output wr_full_o, wr_overflow_o, rd_ready_o, rd_bank_o, rd_count_o, rd_data_o
  );

endinterface

// File: rtl/weight_pingpong_buffer_simple_dual_port_ram.sv
// simple_dual_port_ram
// Storage for both banks of the ping-pong buffer: one synchronous write port
// and one registered, read-first read port.
//   clk_i       : clock, rising edge
//   wpb_rst_n_i : asynchronous active-low reset (read data register only)
//   wr_en_i, wr_addr_i, wr_data_i : write port
//   rd_en_i, rd_addr_i            : read port request
//   rd_data_o                     : read data, valid the cycle after rd_en_i, held otherwise
module simple_dual_port_ram #(
  parameter int unsigned DATA_BITWIDTH = 163,
  parameter int unsigned ADDR_BITWIDTH = 7
) (
  input  logic                     clk_i,
  input  logic                     wpb_rst_n_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_BITWIDTH-1:0] wr_addr_i,
  input  logic [DATA_BITWIDTH-1:0] wr_data_i,
  input  logic                     rd_en_i,
  input  logic [ADDR_BITWIDTH-1:0] rd_addr_i,
  output logic [DATA_BITWIDTH-1:0] rd_data_o
);

  // Sized from the address width so a {bank, addr} address is always in
  // range; for a power-of-two bank depth this is exactly two banks.
  localparam int unsigned WORDS = 1 << ADDR_BITWIDTH;

  logic [DATA_BITWIDTH-1:0] mem [WORDS];

  // The array is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Non-blocking read of the array gives read-first behaviour on a same-address
  // collision with the write port.
  always_ff @(posedge clk_i or negedge wpb_rst_n_i) begin
    if (!wpb_rst_n_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// weight_pingpong_buffer
// Double-banked weight buffer between the DRAM-to-memory packer and the
// PE-array reader. Words are written at internally generated addresses; a bank
// is handed to the reader when it fills or when a tile ends, and the writer
// moves to the other bank. Writes to a bank the reader still owns are dropped
// and flagged through a sticky overflow bit.
//   clk_i       : clock, rising edge
//   wpb_rst_n_i : asynchronous active-low reset
//   bus         : weight_pingpong_buffer_if.slave (write, read and status signals)
module weight_pingpong_buffer
  import weight_pingpong_buffer_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = WPB_DATA_BITWIDTH,
  parameter int unsigned DEPTH         = 64
) (
  input logic                     clk_i,
  input logic                     wpb_rst_n_i,
  weight_pingpong_buffer_if.slave bus
);

  localparam int unsigned ADDR_BITWIDTH     = wpb_addr_bitwidth(DEPTH);
  localparam int unsigned CNT_BITWIDTH      = ADDR_BITWIDTH + 1;
  localparam int unsigned RAM_ADDR_BITWIDTH = WPB_BANK_BITWIDTH + ADDR_BITWIDTH;

  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);
  localparam logic [ADDR_BITWIDTH-1:0] ADDR_ONE  = ADDR_BITWIDTH'(1);
  localparam logic [CNT_BITWIDTH-1:0]  CNT_ONE   = CNT_BITWIDTH'(1);

  wpb_bank_t                          wr_bank;
  logic [ADDR_BITWIDTH-1:0]           wr_addr;
  logic [1:0]                         bank_full;
  logic [1:0][CNT_BITWIDTH-1:0]       bank_cnt;
  wpb_bank_t                          rd_bank;
  logic                               overflow;

  logic wr_full;
  logic rd_ready;
  logic wr_accept;
  logic wr_close;
  logic rd_release;

  assign wr_full    = bank_full[wr_bank];
  assign rd_ready   = bank_full[rd_bank];
  assign wr_accept  = bus.wr_en_i & ~wr_full;
  assign wr_close   = wr_accept & (bus.wr_last_i | (wr_addr == LAST_ADDR));
  assign rd_release = bus.rd_release_i & rd_ready;

  // Write pointer: advance on each accepted word, wrap to the other bank when
  // the current one closes. Rejected writes leave the pointer untouched.
  always_ff @(posedge clk_i or negedge wpb_rst_n_i) begin
    if (!wpb_rst_n_i) begin
      wr_bank <= '0;
      wr_addr <= '0;
    end else if (wr_close) begin
      wr_bank <= ~wr_bank;
      wr_addr <= '0;
    end else if (wr_accept) begin
      wr_addr <= wr_addr + ADDR_ONE;
    end
  end

  // A closing write needs its bank empty and a release needs its bank full, so
  // the two can never hit the same flag in one cycle.
  always_ff @(posedge clk_i or negedge wpb_rst_n_i) begin
    if (!wpb_rst_n_i) begin
      bank_full <= '0;
      bank_cnt  <= '0;
    end else begin
      if (wr_close) begin
        bank_full[wr_bank] <= 1'b1;
        bank_cnt[wr_bank]  <= CNT_BITWIDTH'(wr_addr) + CNT_ONE;
      end
      if (rd_release) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge wpb_rst_n_i) begin
    if (!wpb_rst_n_i) begin
      rd_bank <= '0;
    end else if (rd_release) begin
      rd_bank <= ~rd_bank;
    end
  end

  // Sticky until reset so the fetch logic can detect any lost word after the fact.
  always_ff @(posedge clk_i or negedge wpb_rst_n_i) begin
    if (!wpb_rst_n_i) begin
      overflow <= 1'b0;
    end else if (bus.wr_en_i && wr_full) begin
      overflow <= 1'b1;
    end
  end

  assign bus.wr_full_o     = wr_full;
  assign bus.wr_overflow_o = overflow;
  assign bus.rd_ready_o    = rd_ready;
  assign bus.rd_bank_o     = rd_bank;
  assign bus.rd_count_o    = bank_cnt[rd_bank];

  simple_dual_port_ram #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .ADDR_BITWIDTH (RAM_ADDR_BITWIDTH)
  ) u_ram (
    .clk_i       (clk_i),
    .wpb_rst_n_i (wpb_rst_n_i),
    .wr_en_i     (wr_accept),
    .wr_addr_i   ({wr_bank, wr_addr}),
    .wr_data_i   (bus.wr_data_i),
    .rd_en_i     (bus.rd_en_i),
    .rd_addr_i   ({rd_bank, bus.rd_addr_i}),
    .rd_data_o   (bus.rd_data_o)
  );

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// tb_weight_pingpong_buffer
// Self-checking bench for weight_pingpong_buffer with DEPTH=4: a table of
// directed vectors, a mid-fill reset sequence, then random traffic compared
// against a tile-level reference model.
module tb_weight_pingpong_buffer;
  import weight_pingpong_buffer_pkg::*;

  localparam int DW = WPB_DATA_BITWIDTH;
  localparam int D  = 4;
  localparam int AW = wpb_addr_bitwidth(D);
  localparam int NV = 20;

  logic clk_i = 1'b0;
  logic wpb_rst_n_i = 1'b0;

  always #5 clk_i = ~clk_i;

  weight_pingpong_buffer_if #(.DATA_BITWIDTH(DW), .DEPTH(D)) bus ();

  weight_pingpong_buffer #(.DATA_BITWIDTH(DW), .DEPTH(D)) dut (
    .clk_i       (clk_i),
    .wpb_rst_n_i (wpb_rst_n_i),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: tiles closed and released are counted; the write bank is
  // closes mod 2, the read bank releases mod 2, and the number of banks held
  // by the reader is their difference.
  int               m_closes;
  int               m_releases;
  int               m_fill;
  int               m_cnt [2];
  bit               m_ovf;
  logic [DW-1:0]    m_mem [2*D];
  bit               m_known [2*D];
  logic [DW-1:0]    m_rd;
  bit               m_rd_known;

  typedef struct {
    logic we;
    logic last;
    int   wid;
    logic re;
    int   ra;
    logic rel;
    logic e_full;
    logic e_ovf;
    logic e_ready;
    logic e_bank;
    int   e_count;
    logic e_chk;
    int   e_word;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [DW-1:0] word(input int n);
    logic [DW-1:0] w;
    w = '0;
    w[31:0]      = 32'(n) ^ 32'h5A5A_0000;
    w[95:64]     = ~32'(n);
    w[DW-1 -: 32] = 32'(n) + 32'hC0DE_0000;
    return w;
  endfunction

  function automatic logic [DW-1:0] randWord();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic vec_t mk(input int we, input int last, input int wid,
                              input int re, input int ra, input int rel,
                              input int f, input int o, input int r, input int b,
                              input int c, input int chk, input int ew);
    vec_t v;
    v.we = 1'(we);    v.last = 1'(last); v.wid = wid;
    v.re = 1'(re);    v.ra = ra;         v.rel = 1'(rel);
    v.e_full = 1'(f); v.e_ovf = 1'(o);   v.e_ready = 1'(r);
    v.e_bank = 1'(b); v.e_count = c;     v.e_chk = 1'(chk);
    v.e_word = ew;
    return v;
  endfunction

  function automatic void modelReset();
    m_closes   = 0;
    m_releases = 0;
    m_fill     = 0;
    m_cnt[0]   = 0;
    m_cnt[1]   = 0;
    m_ovf      = 1'b0;
    m_rd       = '0;
    m_rd_known = 1'b1;
  endfunction

  function automatic void modelStep(input bit we, input bit last, input logic [DW-1:0] data,
                                    input bit re, input int ra, input bit rel);
    int held;
    int wb;
    int rb;
    held = m_closes - m_releases;
    wb   = m_closes % 2;
    rb   = m_releases % 2;
    if (re) begin
      m_rd       = m_mem[rb*D + ra];
      m_rd_known = m_known[rb*D + ra];
    end
    if (we) begin
      if (held == 2) begin
        m_ovf = 1'b1;
      end else begin
        m_mem[wb*D + m_fill]   = data;
        m_known[wb*D + m_fill] = 1'b1;
        m_fill++;
        if (last || m_fill == D) begin
          m_cnt[wb] = m_fill;
          m_fill    = 0;
          m_closes++;
        end
      end
    end
    if (rel && held >= 1) m_releases++;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit we, input bit last, input logic [DW-1:0] data,
                               input bit re, input int ra, input bit rel);
    bus.wr_en_i      = we;
    bus.wr_last_i    = last;
    bus.wr_data_i    = data;
    bus.rd_en_i      = re;
    bus.rd_addr_i    = AW'(ra);
    bus.rd_release_i = rel;
    @(posedge clk_i);
    #1;
    modelStep(we, last, data, re, ra, rel);
    bus.wr_en_i      = 1'b0;
    bus.wr_last_i    = 1'b0;
    bus.rd_en_i      = 1'b0;
    bus.rd_release_i = 1'b0;
  endtask

  task automatic checkAgainstModel(input string tag);
    int held;
    held = m_closes - m_releases;
    checkOutput({tag, "_wr_full"},  DW'(bus.wr_full_o),     DW'(held == 2));
    checkOutput({tag, "_overflow"}, DW'(bus.wr_overflow_o), DW'(m_ovf));
    checkOutput({tag, "_rd_ready"}, DW'(bus.rd_ready_o),    DW'(held >= 1));
    checkOutput({tag, "_rd_bank"},  DW'(bus.rd_bank_o),     DW'(m_releases % 2));
    checkOutput({tag, "_rd_count"}, DW'(bus.rd_count_o),    DW'(m_cnt[m_releases % 2]));
    if (m_rd_known) checkOutput({tag, "_rd_data"}, bus.rd_data_o, m_rd);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wr_full"},  DW'(bus.wr_full_o),     '0);
    checkOutput({tag, "_overflow"}, DW'(bus.wr_overflow_o), '0);
    checkOutput({tag, "_rd_ready"}, DW'(bus.rd_ready_o),    '0);
    checkOutput({tag, "_rd_bank"},  DW'(bus.rd_bank_o),     '0);
    checkOutput({tag, "_rd_count"}, DW'(bus.rd_count_o),    '0);
    checkOutput({tag, "_rd_data"},  bus.rd_data_o,          '0);
  endtask

  initial begin
    bus.wr_en_i      = 1'b0;
    bus.wr_last_i    = 1'b0;
    bus.wr_data_i    = '0;
    bus.rd_en_i      = 1'b0;
    bus.rd_addr_i    = '0;
    bus.rd_release_i = 1'b0;
    modelReset();

    //              we last wid re ra rel | full ovf rdy bank cnt chk word
    vecs[0]  = mk(1, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
    vecs[1]  = mk(1, 0,  1, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
    vecs[2]  = mk(1, 0,  2, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0);
    vecs[3]  = mk(1, 0,  3, 0, 0, 0,   0, 0, 1, 0, 4, 0,  0);
    vecs[4]  = mk(0, 0,  0, 1, 0, 0,   0, 0, 1, 0, 4, 1,  0);
    vecs[5]  = mk(0, 0,  0, 1, 1, 0,   0, 0, 1, 0, 4, 1,  1);
    vecs[6]  = mk(0, 0,  0, 1, 2, 0,   0, 0, 1, 0, 4, 1,  2);
    vecs[7]  = mk(0, 0,  0, 1, 3, 0,   0, 0, 1, 0, 4, 1,  3);
    vecs[8]  = mk(1, 0, 10, 0, 0, 0,   0, 0, 1, 0, 4, 0,  0);
    vecs[9]  = mk(1, 1, 11, 0, 0, 1,   0, 0, 1, 1, 2, 0,  0);
    vecs[10] = mk(0, 0,  0, 1, 1, 0,   0, 0, 1, 1, 2, 1, 11);
    vecs[11] = mk(1, 0, 20, 0, 0, 0,   0, 0, 1, 1, 2, 0,  0);
    vecs[12] = mk(1, 1, 21, 0, 0, 0,   1, 0, 1, 1, 2, 0,  0);
    vecs[13] = mk(1, 0, 30, 0, 0, 1,   0, 1, 1, 0, 2, 0,  0);
    vecs[14] = mk(1, 0, 31, 0, 0, 0,   0, 1, 1, 0, 2, 0,  0);
    vecs[15] = mk(0, 0,  0, 1, 0, 0,   0, 1, 1, 0, 2, 1, 20);
    vecs[16] = mk(0, 0,  0, 1, 1, 0,   0, 1, 1, 0, 2, 1, 21);
    vecs[17] = mk(0, 0,  0, 0, 0, 1,   0, 1, 0, 1, 2, 0,  0);
    vecs[18] = mk(0, 0,  0, 0, 0, 1,   0, 1, 0, 1, 2, 0,  0);
    vecs[19] = mk(0, 0,  0, 1, 0, 0,   0, 1, 0, 1, 2, 1, 31);

    repeat (3) @(posedge clk_i);
    #1;
    checkAllZero("reset");
    @(negedge clk_i);
    wpb_rst_n_i = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].we, vecs[i].last, word(vecs[i].wid),
                    vecs[i].re, vecs[i].ra, vecs[i].rel);
      checkOutput($sformatf("vec%0d_wr_full", i),  DW'(bus.wr_full_o),     DW'(vecs[i].e_full));
      checkOutput($sformatf("vec%0d_overflow", i), DW'(bus.wr_overflow_o), DW'(vecs[i].e_ovf));
      checkOutput($sformatf("vec%0d_rd_ready", i), DW'(bus.rd_ready_o),    DW'(vecs[i].e_ready));
      checkOutput($sformatf("vec%0d_rd_bank", i),  DW'(bus.rd_bank_o),     DW'(vecs[i].e_bank));
      checkOutput($sformatf("vec%0d_rd_count", i), DW'(bus.rd_count_o),    DW'(vecs[i].e_count));
      if (vecs[i].e_chk) begin
        checkOutput($sformatf("vec%0d_rd_data", i), bus.rd_data_o, word(vecs[i].e_word));
      end
    end

    // Bank 1 now holds one word; one more puts the write address at 2, then
    // reset lands mid-cycle and must clear every output without a clock edge.
    $display("[TB] reset mid-fill");
    applyStimulus(1'b1, 1'b0, word(40), 1'b0, 0, 1'b0);
    wpb_rst_n_i = 1'b0;
    #2;
    checkAllZero("midreset");
    modelReset();
    @(posedge clk_i);
    @(negedge clk_i);
    wpb_rst_n_i = 1'b1;

    applyStimulus(1'b1, 1'b1, word(50), 1'b0, 0, 1'b0);
    checkOutput("postreset_rd_ready", DW'(bus.rd_ready_o), DW'(1));
    checkOutput("postreset_rd_bank",  DW'(bus.rd_bank_o),  DW'(0));
    checkOutput("postreset_rd_count", DW'(bus.rd_count_o), DW'(1));
    checkOutput("postreset_wr_full",  DW'(bus.wr_full_o),  DW'(0));
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 0, 1'b0);
    checkOutput("postreset_rd_data", bus.rd_data_o, word(50));

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      bit we;
      bit last;
      bit re;
      bit rel;
      we   = ($urandom_range(0, 1) == 1);
      last = ($urandom_range(0, 3) == 0);
      re   = ($urandom_range(0, 1) == 1);
      rel  = ($urandom_range(0, 4) == 0);
      applyStimulus(we, last, randWord(), re, int'($urandom_range(0, D - 1)), rel);
      checkAgainstModel($sformatf("rand%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
